// File: rtl/evp_pkg.sv
// Shared definitions for the polynomial store/evaluate instruction engines.
// Holds slot geometry, completion codes, the store FSM state encoding and a log2 helper.
package evp_pkg;

  localparam int         MAX_COEFFS = 11;
  localparam int         NUM_POLYS  = 8;
  localparam logic [4:0] N_EMPTY    = 5'd31;

  localparam logic [31:0] STP_OK      = 32'd0;
  localparam logic [31:0] STP_BAD_N   = 32'd1;
  localparam logic [31:0] STP_CLEARED = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK_N,
    ST_WR_S,
    ST_WR_N,
    ST_END
  } stp_state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stp_fsm_if.sv
// Instruction, data-buffer and S/N memory signals of the store-polynomial engine.
// master = instruction controller + data buffer side, slave = the engine.
interface stp_fsm_if #(
  parameter int word_size = 16,
  parameter int AW        = 10
);
  logic                 rst_instr;
  logic                 start_stp;
  logic [2:0]           A;
  logic [4:0]           N;
  logic [AW-1:0]        rd_addr_data;
  logic [word_size-1:0] data_in;

  logic                 en_rd_data;
  logic [AW-1:0]        rd_addr_data_updated;
  logic                 en_wr_S;
  logic [6:0]           wr_addr_S;
  logic [word_size-1:0] wr_data_S;
  logic                 en_wr_N;
  logic [2:0]           wr_addr_N;
  logic [4:0]           wr_data_N;
  logic                 done_stp;
  logic [31:0]          status;

  modport master (
    output rst_instr, start_stp, A, N, rd_addr_data, data_in,
    input  en_rd_data, rd_addr_data_updated, en_wr_S, wr_addr_S, wr_data_S,
           en_wr_N, wr_addr_N, wr_data_N, done_stp, status
  );

  modport slave (
    input  rst_instr, start_stp, A, N, rd_addr_data, data_in,
    output en_rd_data, rd_addr_data_updated, en_wr_S, wr_addr_S, wr_data_S,
           en_wr_N, wr_addr_N, wr_data_N, done_stp, status
  );
endinterface

// File: rtl/stp_fsm.sv
// Store-polynomial engine: streams N+1 buffer words into S[A*11+i], then records N in N[A].
// Done N+4 cycles after start (clear: 3, bad N: 2); no backpressure, held in END until rst_instr=0.
module stp_fsm
  import evp_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int num_polys   = NUM_POLYS,
  parameter int max_coeffs  = MAX_COEFFS
) (
  input logic      clk,
  input logic      rst,
  stp_fsm_if.slave bus
);

  localparam int            AW       = log2(buffer_size);
  localparam int            SLOT_W   = log2(num_polys);
  localparam logic [4:0]    N_MAX    = 5'(max_coeffs - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(buffer_size - 1);

  stp_state_t state_q, state_nx;

  logic [SLOT_W-1:0] a_q;
  logic [4:0]        n_q;
  logic [3:0]        i_q;
  logic [AW-1:0]     ptr_q;
  logic [AW-1:0]     ptr_inc;
  logic [6:0]        a_ext;
  logic [6:0]        slot_base;

  logic        en_rd_q;
  logic        en_wr_s_q;
  logic        en_wr_n_q;
  logic        done_q;
  logic [31:0] status_q;
  logic [31:0] status_nx;

  assign a_ext     = 7'(a_q);
  assign slot_base = (a_ext << 3) + (a_ext << 1) + a_ext;
  assign ptr_inc   = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_stp) state_nx = ST_CHECK_N;
      end
      ST_CHECK_N: begin
        if (n_q <= N_MAX)          state_nx = ST_WR_S;
        else if (n_q == N_EMPTY)   state_nx = ST_WR_N;
        else                       state_nx = ST_END;
      end
      ST_WR_S: begin
        if ({1'b0, i_q} == n_q) state_nx = ST_WR_N;
      end
      ST_WR_N: state_nx = ST_END;
      ST_END:  state_nx = ST_END;
      default: state_nx = ST_IDLE;
    endcase
    // Instruction reset overrides everything, including a start in IDLE.
    if (!bus.rst_instr) state_nx = ST_IDLE;
  end

  always_comb begin
    status_nx = '0;
    if (state_nx == ST_END) begin
      unique case (state_q)
        ST_CHECK_N: status_nx = STP_BAD_N;
        ST_WR_N:    status_nx = (n_q == N_EMPTY) ? STP_CLEARED : STP_OK;
        default:    status_nx = status_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      n_q       <= '0;
      i_q       <= '0;
      ptr_q     <= '0;
      en_rd_q   <= 1'b0;
      en_wr_s_q <= 1'b0;
      en_wr_n_q <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_nx;
      en_rd_q   <= (state_nx == ST_WR_S);
      en_wr_s_q <= (state_nx == ST_WR_S);
      en_wr_n_q <= (state_nx == ST_WR_N);
      done_q    <= (state_nx == ST_END);
      status_q  <= status_nx;
      if (state_q == ST_IDLE && state_nx == ST_CHECK_N) begin
        a_q   <= bus.A[SLOT_W-1:0];
        n_q   <= bus.N;
        ptr_q <= bus.rd_addr_data;
        i_q   <= '0;
      end
      // The word at ptr_q is consumed every WR_S cycle, even on an abort edge.
      if (state_q == ST_WR_S) begin
        ptr_q <= ptr_inc;
        i_q   <= i_q + 4'd1;
      end
    end
  end

  assign bus.en_rd_data           = en_rd_q;
  assign bus.rd_addr_data_updated = ptr_q;
  assign bus.en_wr_S              = en_wr_s_q;
  assign bus.wr_addr_S            = (state_q == ST_WR_S) ? slot_base + 7'(i_q) : '0;
  assign bus.wr_data_S            = (state_q == ST_WR_S) ? bus.data_in : '0;
  assign bus.en_wr_N              = en_wr_n_q;
  assign bus.wr_addr_N            = (state_q == ST_WR_N) ? 3'(a_q) : '0;
  assign bus.wr_data_N            = (state_q == ST_WR_N) ? n_q : '0;
  assign bus.done_stp             = done_q;
  assign bus.status               = status_q;

endmodule

// File: tb/tb_stp_fsm.sv
// Bench for stp_fsm: per-cycle schedule model of each store instruction plus emulated S/N memories.
module tb_stp_fsm;
  import evp_pkg::*;

  localparam int W  = 16;
  localparam int BS = 1024;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stp_fsm_if #(.word_size(W), .AW(AW)) bus ();

  stp_fsm #(.word_size(W), .buffer_size(BS), .num_polys(8), .max_coeffs(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int en_rd_cnt = 0;
  bit checking = 1'b0;

  logic [W-1:0] dbuf  [BS];
  logic [W-1:0] s_dut [88];
  logic [W-1:0] s_ref [88];
  logic [4:0]   n_dut [8];
  logic [4:0]   n_ref [8];

  assign bus.data_in = dbuf[bus.rd_addr_data_updated];

  typedef struct packed {
    logic        en_rd;
    logic        en_ws;
    logic [6:0]  as;
    logic [15:0] ds;
    logic        en_wn;
    logic [2:0]  an;
    logic [4:0]  dn;
    logic        done;
    logic [31:0] st;
    logic [9:0]  ptr;
  } exp_t;

  exp_t sched[$];
  exp_t cur = '0;
  bit   in_end = 1'b0;
  bit   ptr_known = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected outputs of every cycle from the one after the start edge to the held END cycle.
  task automatic build(input int a, input int n, input int p);
    exp_t e;
    int q;
    e = '0; e.ptr = 10'(p);
    sched.push_back(e);
    if (n <= 10) begin
      for (int j = 0; j <= n; j++) begin
        q = (p + j) % BS;
        e = '0; e.en_rd = 1'b1; e.en_ws = 1'b1; e.as = 7'(a * 11 + j);
        e.ds = dbuf[10'(q)]; e.ptr = 10'(q);
        sched.push_back(e);
      end
      q = (p + n + 1) % BS;
      e = '0; e.en_wn = 1'b1; e.an = 3'(a); e.dn = 5'(n); e.ptr = 10'(q);
      sched.push_back(e);
      e = '0; e.done = 1'b1; e.st = STP_OK; e.ptr = 10'(q);
      sched.push_back(e);
    end else if (n == 31) begin
      e = '0; e.en_wn = 1'b1; e.an = 3'(a); e.dn = 5'd31; e.ptr = 10'(p);
      sched.push_back(e);
      e = '0; e.done = 1'b1; e.st = STP_CLEARED; e.ptr = 10'(p);
      sched.push_back(e);
    end else begin
      e = '0; e.done = 1'b1; e.st = STP_BAD_N; e.ptr = 10'(p);
      sched.push_back(e);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      in_end    = 1'b0;
      cur       = '0;
      ptr_known = 1'b1;
    end else begin
      if (cur.en_ws) s_ref[cur.as] = cur.ds;
      if (cur.en_wn) n_ref[cur.an] = cur.dn;
      if (!bus.rst_instr) begin
        // Whether an aborted read advances the pointer is left open; stop checking it until reload.
        if (cur.en_rd) ptr_known = 1'b0;
        sched.delete();
        in_end = 1'b0;
        cur = '{ptr: cur.ptr, default: '0};
      end else if (!in_end) begin
        if (sched.size() > 0) begin
          cur = sched.pop_front();
          if (sched.size() == 0) in_end = 1'b1;
        end else if (bus.start_stp) begin
          build(int'(bus.A), int'(bus.N), int'(bus.rd_addr_data));
          cur = sched.pop_front();
          ptr_known = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.en_wr_S && bus.wr_addr_S < 7'd88) s_dut[bus.wr_addr_S] = bus.wr_data_S;
      if (bus.en_wr_N) n_dut[bus.wr_addr_N] = bus.wr_data_N;
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      if (bus.en_rd_data) en_rd_cnt++;
      chk("en_rd_data", 32'(bus.en_rd_data), 32'(cur.en_rd));
      chk("en_wr_S",    32'(bus.en_wr_S),    32'(cur.en_ws));
      chk("wr_addr_S",  32'(bus.wr_addr_S),  32'(cur.as));
      chk("wr_data_S",  32'(bus.wr_data_S),  32'(cur.ds));
      chk("en_wr_N",    32'(bus.en_wr_N),    32'(cur.en_wn));
      chk("wr_addr_N",  32'(bus.wr_addr_N),  32'(cur.an));
      chk("wr_data_N",  32'(bus.wr_data_N),  32'(cur.dn));
      chk("done_stp",   32'(bus.done_stp),   32'(cur.done));
      chk("status",     bus.status,          cur.st);
      if (ptr_known) chk("rd_addr_data_updated", 32'(bus.rd_addr_data_updated), 32'(cur.ptr));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, ".en_rd_data"}, 32'(bus.en_rd_data), 0);
    chk({tag, ".en_wr_S"},    32'(bus.en_wr_S), 0);
    chk({tag, ".wr_addr_S"},  32'(bus.wr_addr_S), 0);
    chk({tag, ".wr_data_S"},  32'(bus.wr_data_S), 0);
    chk({tag, ".en_wr_N"},    32'(bus.en_wr_N), 0);
    chk({tag, ".wr_data_N"},  32'(bus.wr_data_N), 0);
    chk({tag, ".done_stp"},   32'(bus.done_stp), 0);
    chk({tag, ".status"},     bus.status, 0);
    chk({tag, ".ptr"},        32'(bus.rd_addr_data_updated), 0);
  endtask

  // Issues one instruction; returns latency, status and pointer seen in the first done cycle.
  task automatic run_op(input int a, input int n, input int p, input int abort_c,
                        output int lat, output int st, output int ptr);
    int exp_lat;
    exp_lat = (n <= 10) ? n + 4 : (n == 31) ? 3 : 2;
    lat = -1; st = -1; ptr = -1;
    @(negedge clk);
    bus.rst_instr = 1'b1; bus.start_stp = 1'b1;
    bus.A = 3'(a); bus.N = 5'(n); bus.rd_addr_data = 10'(p);
    @(negedge clk);
    bus.start_stp = 1'b0;
    bus.A = 3'($urandom); bus.N = 5'($urandom); bus.rd_addr_data = 10'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (abort_c == c) begin
        bus.rst_instr = 1'b0;
        @(negedge clk);
        bus.rst_instr = 1'b1; bus.start_stp = 1'b0;
        return;
      end
      if (bus.done_stp) begin
        lat = c; st = int'(bus.status); ptr = int'(bus.rd_addr_data_updated);
        break;
      end
      @(negedge clk);
      bus.start_stp = 1'($urandom);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.start_stp = 1'($urandom);
    end
    @(negedge clk);
    bus.rst_instr = 1'b0; bus.start_stp = 1'($urandom);
    @(negedge clk);
    bus.rst_instr = 1'b1; bus.start_stp = 1'b0;
  endtask

  initial begin
    int lat, st, ptr, a, n, p, ab, el, kind;
    rst = 1'b1;
    bus.rst_instr = 1'b1; bus.start_stp = 1'b0;
    bus.A = '0; bus.N = '0; bus.rd_addr_data = '0;
    for (int i = 0; i < BS; i++) dbuf[i] = W'($urandom);
    for (int i = 0; i < 88; i++) begin s_dut[i] = 16'hDEAD; s_ref[i] = 16'hDEAD; end
    for (int i = 0; i < 8; i++) begin n_dut[i] = 5'd20; n_ref[i] = 5'd20; end

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Degree 0 into slot 1
    dbuf[1] = 16'd25432;
    run_op(1, 0, 1, 0, lat, st, ptr);
    chk("t1.status", 32'(st), 0);
    chk("t1.ptr", 32'(ptr), 2);
    chk("t1.S11", 32'(s_dut[11]), 25432);
    chk("t1.N1", 32'(n_dut[1]), 0);

    // Full degree into the last slot with pointer wrap
    for (int j = 0; j <= 10; j++) dbuf[(1020 + j) % BS] = W'(100 + j);
    run_op(7, 10, 1020, 0, lat, st, ptr);
    chk("t2.latency", 32'(lat), 14);
    chk("t2.ptr", 32'(ptr), 7);
    chk("t2.S77", 32'(s_dut[77]), 100);
    chk("t2.S80", 32'(s_dut[80]), 103);
    chk("t2.S81", 32'(s_dut[81]), 104);
    chk("t2.S87", 32'(s_dut[87]), 110);
    chk("t2.N7", 32'(n_dut[7]), 10);

    // Invalid degree
    en_rd_cnt = 0;
    run_op(2, 15, 7, 0, lat, st, ptr);
    chk("t3.latency", 32'(lat), 2);
    chk("t3.status", 32'(st), 1);
    chk("t3.ptr", 32'(ptr), 7);
    chk("t3.en_rd_cycles", 32'(en_rd_cnt), 0);
    chk("t3.N2", 32'(n_dut[2]), 20);

    // Clear slot 3
    run_op(3, 31, 40, 0, lat, st, ptr);
    chk("t4.latency", 32'(lat), 3);
    chk("t4.status", 32'(st), 2);
    chk("t4.N3", 32'(n_dut[3]), 31);

    // Instruction reset during the third coefficient write
    run_op(0, 5, 200, 4, lat, st, ptr);
    chk("t5.done_seen", 32'(lat), 32'hFFFF_FFFF);
    chk("t5.S0", 32'(s_dut[0]), 32'(dbuf[200]));
    chk("t5.S2", 32'(s_dut[2]), 32'(dbuf[202]));
    chk("t5.S3", 32'(s_dut[3]), 32'h0000_DEAD);
    chk("t5.N0", 32'(n_dut[0]), 20);

    // Asynchronous reset during the third coefficient write
    @(negedge clk);
    bus.start_stp = 1'b1; bus.A = 3'd0; bus.N = 5'd5; bus.rd_addr_data = 10'd300;
    @(negedge clk);
    bus.start_stp = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5r.en_wr_S_before", 32'(bus.en_wr_S), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("t5r");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back store after the degree-0 one
    dbuf[1] = 16'd25432; dbuf[2] = 16'd111; dbuf[3] = 16'd222;
    run_op(1, 0, 1, 0, lat, st, ptr);
    run_op(1, 1, 2, 0, lat, st, ptr);
    chk("t6.latency", 32'(lat), 5);
    chk("t6.ptr", 32'(ptr), 4);
    chk("t6.S11", 32'(s_dut[11]), 111);
    chk("t6.S12", 32'(s_dut[12]), 222);
    chk("t6.N1", 32'(n_dut[1]), 1);

    // Randomized instructions, aborts and blocked starts
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 9));
      n = (kind == 0) ? 31 : (kind == 1) ? int'($urandom_range(11, 30)) : int'($urandom_range(0, 10));
      a = int'($urandom_range(0, 7));
      p = int'($urandom_range(0, BS - 1));
      el = (n <= 10) ? n + 4 : (n == 31) ? 3 : 2;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, el - 1)) : 0;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.rst_instr = 1'($urandom);
        bus.start_stp = ~bus.rst_instr;
        bus.A = 3'($urandom); bus.N = 5'($urandom); bus.rd_addr_data = 10'($urandom);
      end
      run_op(a, n, p, ab, lat, st, ptr);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 88; i++) chk("S_mem", 32'(s_dut[i]), 32'(s_ref[i]));
    for (int i = 0; i < 8; i++)  chk("N_mem", 32'(n_dut[i]), 32'(n_ref[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stp_fsm.md
Name: stp_fsm

Overview:
Store-polynomial instruction engine: the writer side of the coefficient/degree memories that the polynomial-evaluation FSM reads.
- On start_stp it takes a slot number A and degree N, and pulls N+1 coefficients sequentially from the input data buffer.
- It writes them to the S memory at A*11+i, then writes N to the N memory at A.
- Sits beside the evaluation FSM under the same instruction controller and shares the data-buffer read pointer handoff (rd_addr_data in, rd_addr_data_updated out).

Parameters:
word_size, 16, coefficient / data-buffer word width
buffer_size, 1024, data-buffer depth; pointer width AW = log2(buffer_size)
num_polys, 8, polynomial slots (A range 0..7)
max_coeffs, 11, coefficients per slot (degree 0..10); S depth = 88

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rst_instr  in  1  synchronous instruction reset, active-low; 0 forces IDLE at next edge
start_stp  in  1  start pulse, sampled in IDLE
A  in  3  target slot
N  in  5  degree; 0..10 valid, 31 = clear slot, 11..30 invalid
rd_addr_data  in  AW  data-buffer read pointer at start
data_in  in  word_size  data-buffer word at rd_addr_data_updated (combinational read, same cycle)
en_rd_data  out  1  data-buffer read enable
rd_addr_data_updated  out  AW  internal read pointer (current read address; next unread address after done)
en_wr_S  out  1  S write enable
wr_addr_S  out  7  S write address = A*11+i
wr_data_S  out  word_size  S write data
en_wr_N  out  1  N write enable
wr_addr_N  out  3  N write address = A
wr_data_N  out  5  N write data
done_stp  out  1  instruction complete
status  out  32  completion code, valid while done_stp=1

Behaviour:
- Reset (rst=1, asynchronous): state IDLE, pointer 0, i 0, and every output 0.
- All enables and write buses are 0 outside the states listed below. All outputs are registered, except the write buses, which are decoded from state/regs; wr_data_S = data_in.
- IDLE: if start_stp=1 at an edge, latch A, N and rd_addr_data into the pointer; clear i; go to CHECK_N. Otherwise stay.
- CHECK_N (1 cycle, no enables):
  - N<=10: go to WR_S.
  - N==31: go to WR_N.
  - Otherwise: status=1, go to END.
- WR_S (N+1 cycles):
  - Per cycle: en_rd_data=1, en_wr_S=1, wr_addr_S=A*11+i.
  - At the edge: pointer=(pointer+1) mod buffer_size; i++. When i==N, go to WR_N.
- WR_N (1 cycle): en_wr_N=1, wr_addr_N=A, wr_data_N=N (31 for a clear). status=0 for a valid store, 2 for a clear. Go to END.
- END: done_stp=1 and status stay held until rst_instr=0, then go to IDLE (done and status cleared, pointer retained). start_stp is ignored in END.
- Latency (start edge = cycle 0):
  - Valid N=k: done_stp high in cycle k+4.
  - Clear: done_stp high in cycle 3.
  - Invalid N: done_stp high in cycle 2.
- Pointer wraps from buffer_size-1 to 0. The S address never exceeds 87 for a legal A/N.
- rst_instr=0 in any non-IDLE state: go to IDLE at the next edge. S writes already made stay; N is not written; no done.
- rst mid-operation: immediate asynchronous clear of all outputs; the partial store is abandoned.
- A*11 is computed as (A<<3)+(A<<1)+A, 7-bit, no overflow for A<=7.

Decomposition:
- Shared package evp_pkg holds:
  - MAX_COEFFS=11, NUM_POLYS=8, N_EMPTY=5'd31
  - status codes STP_OK=0, STP_BAD_N=1, STP_CLEARED=2
  - the state encoding
  - the log2 function, also used by the evaluation FSM
- No sub-module: the slot-address multiply and the pointer wrap are inline.

Test Plan:
1. A=1, N=0, rd_addr_data=1, data[1]=25432 -> cycle 2: en_wr_S, wr_addr_S=11, wr_data_S=25432. Cycle 3: N[1]=0 written. Cycle 4: done_stp=1, status=0, rd_addr_data_updated=2.
2. A=7, N=10, rd_addr_data=1020, data 100..110 -> S[77..87]=100..110. Pointer wraps 1023->0. rd_addr_data_updated=7. N[7]=10. Done at cycle 14.
3. A=2, N=15 -> no S or N writes, en_rd_data never high, done at cycle 2, status=1, pointer unchanged.
4. A=3, N=31 -> no S writes, en_wr_N with wr_addr_N=3, wr_data_N=31, done at cycle 3, status=2.
5. A=0, N=5, then rst_instr=0 during the third WR_S cycle -> S[0..2] written, no N write, no done, IDLE next edge. Repeat with rst=1 instead -> all outputs 0 immediately.
6. Back-to-back: finish test 1, pulse rst_instr=0, then start A=1, N=1 with rd_addr_data=2 -> S[11..12] written from data[2..3], N[1]=1, done at cycle 5.
